// File: rtl/synth_pkg.sv
// Shared types and defaults for the harmonic synth sample path.
package synth_pkg;

    typedef logic signed [31:0] sample_t;
    typedef logic [63:0]        time_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_TICK  = 3'd1,
        ST_FIRE       = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_STORE      = 3'd4
    } seq_state_e;

    localparam int CLKS_PER_SAMPLE_DEFAULT = 1024;
    localparam int SEQ_TIMEOUT_DEFAULT     = 512;
    localparam int FIFO_DEPTH_DEFAULT      = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mod_sample_fifo.sv
// First-word-fall-through sample FIFO; full/empty from pointers carrying one extra wrap bit.
module mod_sample_fifo
    import synth_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  sample_t i_data,
    output logic    o_full,
    input  logic    i_pop,
    output logic    o_empty,
    output sample_t o_head
);

    localparam int AW = $clog2(DEPTH);

    sample_t       mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push, do_pop;
    logic          full_s, empty_s;

    // Pointer update; a push while full only lands if the head is leaving this cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        empty_s = (wptr_q == rptr_q);
        full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = i_pop && !empty_s;
        do_push = i_push && (!full_s || do_pop);
        if (do_push) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= i_data;
        end
    end

    assign o_full  = full_s;
    assign o_empty = empty_s;
    // Stale storage is masked so an empty FIFO always presents zero.
    assign o_head  = empty_s ? sample_t'(32'sd0) : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/mod_synth_sequencer_chk.sv
// Simulation-only checks on the sequencer's internal timing invariants.
module mod_synth_sequencer_chk
    import synth_pkg::*;
(
    input logic       i_clk,
    input logic       i_rst,
    input logic       i_tick,
    input seq_state_e i_state,
    input logic       i_trigger
);

    a_tick_only_in_wait: assert property (@(posedge i_clk) disable iff (i_rst)
        i_tick |-> (i_state == ST_WAIT_TICK));

    a_trigger_single: assert property (@(posedge i_clk) disable iff (i_rst)
        i_trigger |=> !i_trigger);

    a_trigger_in_fire: assert property (@(posedge i_clk) disable iff (i_rst)
        i_trigger |-> (i_state == ST_FIRE));

endmodule

// File: rtl/mod_synth_sequencer.sv
// Sample-rate scheduler: divides the clock to the sample rate, triggers the synth,
// captures its answer (or reuses the last one on timeout) and queues it for the codec.
module mod_synth_sequencer
    import synth_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = CLKS_PER_SAMPLE_DEFAULT,
    parameter int TIMEOUT         = SEQ_TIMEOUT_DEFAULT,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic [63:0] o_time,
    output logic        o_trigger,
    input  logic [31:0] i_sound,
    input  logic        i_sound_ready,
    output logic [31:0] o_sample,
    output logic        o_sample_valid,
    input  logic        i_sample_ready,
    output logic        o_busy,
    output logic [15:0] o_overrun_count,
    output logic [15:0] o_timeout_count
);

    localparam int DIV_W = $clog2(CLKS_PER_SAMPLE);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    sample_t          held_q, held_d;
    time_t            time_q, time_d;
    logic [15:0]      overrun_q, overrun_d;
    logic [15:0]      timeout_q, timeout_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    sample_t          fifo_head;

    // Divider, sequencing FSM and saturating event counters.
    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        wait_d    = '0;
        held_d    = held_q;
        time_d    = time_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        fifo_push = 1'b0;
        fifo_pop  = !fifo_empty && i_sample_ready;
        tick      = (div_q == DIV_LAST);

        if (state_q == ST_IDLE) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_WAIT_TICK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_TICK: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_FIRE;
                end else begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                wait_d = wait_q + TO_W'(1);
                // Ready wins over a coincident expiry.
                if (i_sound_ready) begin
                    held_d  = sample_t'(i_sound);
                    state_d = ST_STORE;
                end else if (wait_q == TO_LAST) begin
                    timeout_d = sat_inc16(timeout_q);
                    state_d   = ST_STORE;
                end else begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_STORE: begin
                fifo_push = 1'b1;
                time_d    = time_q + 64'd1;
                state_d   = ST_WAIT_TICK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_push && fifo_full && !fifo_pop) begin
            overrun_d = sat_inc16(overrun_q);
        end else begin
            overrun_d = overrun_q;
        end

        trigger_d = (state_d == ST_FIRE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            wait_q    <= '0;
            held_q    <= '0;
            time_q    <= '0;
            overrun_q <= '0;
            timeout_q <= '0;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            wait_q    <= wait_d;
            held_q    <= held_d;
            time_q    <= time_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
        end
    end

    mod_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_data  (held_q),
        .o_full  (fifo_full),
        .i_pop   (fifo_pop),
        .o_empty (fifo_empty),
        .o_head  (fifo_head)
    );

    mod_synth_sequencer_chk u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_tick    (tick),
        .i_state   (state_q),
        .i_trigger (trigger_q)
    );

    assign o_time          = time_q;
    assign o_trigger       = trigger_q;
    assign o_busy          = busy_q;
    assign o_sample        = fifo_head;
    assign o_sample_valid  = !fifo_empty;
    assign o_overrun_count = overrun_q;
    assign o_timeout_count = timeout_q;

endmodule

// File: tb/tb_mod_synth_sequencer.sv
// Scoreboard bench for mod_synth_sequencer: directed sequences, expected samples queued
// up front and checked by an independent monitor whenever the codec side pops.
module tb_mod_synth_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [63:0] o_time;
    logic        o_trigger;
    logic [31:0] i_sound = 32'd0;
    logic        i_sound_ready = 1'b0;
    logic [31:0] o_sample;
    logic        o_sample_valid;
    logic        i_sample_ready;
    logic        o_busy;
    logic [15:0] o_overrun_count;
    logic [15:0] o_timeout_count;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          trig_cnt = 0;
    logic [31:0] exp_q [$];

    int          syn_delay;
    logic        syn_fixed;
    logic [31:0] syn_value;
    int          syn_cd = 0;

    int          c0, c1, tc;
    int          t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14, t15, t16;

    mod_synth_sequencer #(
        .CLKS_PER_SAMPLE (16),
        .TIMEOUT         (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_enable        (i_enable),
        .o_time          (o_time),
        .o_trigger       (o_trigger),
        .i_sound         (i_sound),
        .i_sound_ready   (i_sound_ready),
        .o_sample        (o_sample),
        .o_sample_valid  (o_sample_valid),
        .i_sample_ready  (i_sample_ready),
        .o_busy          (o_busy),
        .o_overrun_count (o_overrun_count),
        .o_timeout_count (o_timeout_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic nstep(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_trig(output int t);
        int n = 0;
        @(negedge i_clk);
        while (!o_trigger && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_trigger) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL trigger_wait: got no trigger expected one within 200 cycles");
        end
        t = cyc;
    endtask

    // Synth model: answers syn_delay cycles after the trigger cycle (0 = never answers).
    always begin
        @(posedge i_clk or posedge i_rst);
        #1;
        if (i_rst) begin
            syn_cd        = 0;
            i_sound_ready = 1'b0;
            i_sound       = 32'd0;
        end else if (o_trigger) begin
            syn_cd        = syn_delay;
            i_sound_ready = 1'b0;
            i_sound       = syn_fixed ? syn_value : 32'(o_time * 64'd100);
        end else if (syn_cd > 0) begin
            syn_cd--;
            i_sound_ready = (syn_cd == 0);
        end else begin
            i_sound_ready = 1'b0;
        end
    end

    // Monitor: every accepted sample is compared with the scoreboard head.
    always @(negedge i_clk) begin
        if (o_trigger) trig_cnt++;
        if (!i_rst && o_sample_valid && i_sample_ready) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_sample: got %0h expected no sample", o_sample);
            end else begin
                chk("sample", 64'(o_sample), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        i_rst          = 1'b1;
        i_enable       = 1'b0;
        i_sample_ready = 1'b1;
        syn_delay      = 3;
        syn_fixed      = 1'b0;
        syn_value      = 32'd0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_time",    o_time, 64'd0);
        chk("rst_trigger", 64'(o_trigger), 64'd0);
        chk("rst_valid",   64'(o_sample_valid), 64'd0);
        chk("rst_sample",  64'(o_sample), 64'd0);
        chk("rst_busy",    64'(o_busy), 64'd0);
        chk("rst_overrun", 64'(o_overrun_count), 64'd0);
        chk("rst_timeout", 64'(o_timeout_count), 64'd0);
        step(1);
        i_rst = 1'b0;
        step(2);

        // Basic run: samples 0,100,200 at 16-cycle spacing.
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd200);
        c0 = cyc;
        i_enable = 1'b1;
        wait_trig(t1);
        chk("first_trig_cycle", 64'(t1), 64'(c0 + 17));
        chk("time_0", o_time, 64'd0);
        @(negedge i_clk);
        chk("trig_one_cycle", 64'(o_trigger), 64'd0);
        wait_trig(t2);
        chk("trig_period_1", 64'(t2 - t1), 64'd16);
        chk("time_1", o_time, 64'd1);
        wait_trig(t3);
        chk("trig_period_2", 64'(t3 - t2), 64'd16);
        chk("time_2", o_time, 64'd2);
        syn_fixed = 1'b1;
        syn_value = 32'h1234;
        exp_q.push_back(32'h1234);
        nstep(5);
        chk("basic_overrun", 64'(o_overrun_count), 64'd0);
        chk("basic_timeout", 64'(o_timeout_count), 64'd0);

        // Timeout: answer 0x1234 once, then silence; held value is pushed again.
        wait_trig(t4);
        chk("time_3", o_time, 64'd3);
        syn_value = 32'hDEAD;
        syn_delay = 0;
        exp_q.push_back(32'h1234);
        wait_trig(t5);
        chk("time_4", o_time, 64'd4);
        nstep(8);
        chk("timeout_before", 64'(o_timeout_count), 64'd0);
        nstep(1);
        chk("timeout_after", 64'(o_timeout_count), 64'd1);

        // Ready coincident with expiry counts as ready.
        syn_fixed = 1'b0;
        syn_delay = 8;
        exp_q.push_back(32'd500);
        wait_trig(t6);
        chk("time_5", o_time, 64'd5);
        nstep(9);
        chk("ready_at_expiry", 64'(o_timeout_count), 64'd1);

        // Backpressure: 6 samples with no pops, first 4 kept.
        syn_delay = 3;
        exp_q.push_back(32'd600);
        exp_q.push_back(32'd700);
        exp_q.push_back(32'd800);
        exp_q.push_back(32'd900);
        wait_trig(t7);
        step(1);
        i_sample_ready = 1'b0;
        wait_trig(t8);
        wait_trig(t9);
        wait_trig(t10);
        wait_trig(t11);
        nstep(5);
        chk("overrun_1", 64'(o_overrun_count), 64'd1);
        wait_trig(t12);
        nstep(5);
        chk("overrun_2", 64'(o_overrun_count), 64'd2);

        // Full FIFO with pop in the STORE cycle: 600 leaves, 1200 enters, no overrun.
        exp_q.push_back(32'd1200);
        wait_trig(t13);
        step(4);
        i_sample_ready = 1'b1;
        step(1);
        i_sample_ready = 1'b0;
        @(negedge i_clk);
        chk("full_pop_overrun", 64'(o_overrun_count), 64'd2);
        chk("full_pop_head", 64'(o_sample), 64'd700);
        chk("full_pop_valid", 64'(o_sample_valid), 64'd1);
        exp_q.push_back(32'd1300);
        step(1);
        i_sample_ready = 1'b1;
        nstep(5);
        chk("drained_empty", 64'(o_sample_valid), 64'd0);

        // Disable during WAIT_READY: sample completes, then IDLE.
        wait_trig(t14);
        chk("time_13", o_time, 64'd13);
        step(1);
        i_enable = 1'b0;
        nstep(6);
        chk("disable_busy", 64'(o_busy), 64'd0);
        chk("disable_time", o_time, 64'd14);
        tc = trig_cnt;
        nstep(40);
        chk("disable_no_trig", 64'(trig_cnt), 64'(tc));
        chk("disable_busy_hold", 64'(o_busy), 64'd0);
        chk("disable_time_hold", o_time, 64'd14);

        // Re-enable resumes at the retained time.
        exp_q.push_back(32'd1400);
        step(1);
        c1 = cyc;
        i_enable = 1'b1;
        wait_trig(t15);
        chk("reenable_trig_cycle", 64'(t15), 64'(c1 + 17));
        chk("reenable_time", o_time, 64'd14);

        // Async reset mid-WAIT_READY, away from the clock edge.
        wait_trig(t16);
        chk("time_15", o_time, 64'd15);
        step(1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_busy",    64'(o_busy), 64'd0);
        chk("arst_trigger", 64'(o_trigger), 64'd0);
        chk("arst_time",    o_time, 64'd0);
        chk("arst_valid",   64'(o_sample_valid), 64'd0);
        chk("arst_overrun", 64'(o_overrun_count), 64'd0);
        chk("arst_timeout", 64'(o_timeout_count), 64'd0);
        i_enable = 1'b0;
        step(3);
        i_rst = 1'b0;
        nstep(30);
        chk("arst_no_push", 64'(o_sample_valid), 64'd0);
        chk("arst_busy_idle", 64'(o_busy), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mod_synth_sequencer.md
Name: mod_synth_sequencer

Overview:
- Sample-rate scheduler for the harmonic synth.
- Divides the system clock down to the audio sample rate and owns the 64-bit time tick.
- Pulses the synth trigger once per sample, waits for the synth's ready pulse (with timeout) and captures the sound word.
- Buffers captured samples in a small FIFO with a valid/ready handshake toward the codec/serializer.

Parameters:
- CLKS_PER_SAMPLE, 1024: clock cycles per audio sample. Must be >= TIMEOUT + 4.
- TIMEOUT, 512: max cycles to wait for synth ready after a trigger.
- FIFO_DEPTH, 4: output sample buffer entries. Must be a power of two, >= 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enable  in  1  run/stop request.
- o_time  out  64  current time tick to synth, unsigned.
- o_trigger  out  1  one-cycle synth start pulse.
- i_sound  in  32  synth output, signed.
- i_sound_ready  in  1  synth ready pulse.
- o_sample  out  32  FIFO head sample, signed.
- o_sample_valid  out  1  FIFO non-empty.
- i_sample_ready  in  1  downstream accepts head.
- o_busy  out  1  FSM not in IDLE.
- o_overrun_count  out  16  samples dropped on full FIFO, saturating.
- o_timeout_count  out  16  synth timeouts, saturating.

Behaviour:
- Reset (async, i_rst=1) values:
  - All outputs 0, FIFO empty, FSM in IDLE.
  - Divider, held sample and counters cleared.
  - Reset mid-operation aborts immediately; no sample is pushed.
- Divider:
  - Counts 0..CLKS_PER_SAMPLE-1 only while the FSM is outside IDLE.
  - tick = (count == CLKS_PER_SAMPLE-1); count wraps to 0 on tick.
  - Forced to 0 in IDLE.
- FSM states: IDLE, WAIT_TICK, FIRE, WAIT_READY, STORE.
  - IDLE -> WAIT_TICK when i_enable=1. The first tick arrives CLKS_PER_SAMPLE cycles later.
  - WAIT_TICK -> FIRE on tick. If i_enable=0 here, go to IDLE instead; o_time is retained.
  - FIRE: o_trigger=1 for exactly this cycle. Next state WAIT_READY. i_sound_ready is ignored in FIRE.
  - WAIT_READY:
    - On i_sound_ready=1, capture i_sound into the held-sample register, go to STORE.
    - If TIMEOUT cycles elapse without ready, the held sample is reused (not updated), o_timeout_count increments, go to STORE.
    - Ready arriving in the same cycle as expiry counts as ready, not a timeout.
  - STORE:
    - Push the held sample into the FIFO.
    - o_time increments by 1, wrapping at 2^64.
    - Next state WAIT_TICK.
    - i_enable=0 is honoured only in WAIT_TICK, so an in-flight sample always completes.
- o_time is stable from FIRE through STORE. It changes only at STORE exit.
- Tick cannot occur outside WAIT_TICK, given the CLKS_PER_SAMPLE constraint. Add a simulation assertion that fires if it does.
- FIFO:
  - First-word-fall-through: o_sample is the head whenever o_sample_valid=1.
  - Pop when valid && i_sample_ready. Pop has no effect when empty.
  - Push when full without a same-cycle pop: the sample is dropped and o_overrun_count increments.
  - Push and pop in the same cycle while full: both take effect, no overrun.
  - Push and pop in the same cycle while empty: the pushed word appears the next cycle. No bypass.
- Counters: saturate at 16'hFFFF and clear only on reset.
- Trigger-to-push latency: 2 + (cycles until ready) cycles.

Decomposition:
- Package synth_pkg:
  - sample_t (logic signed [31:0]).
  - time_t (logic unsigned [63:0]).
  - seq_state_e enum.
  - Default constants CLKS_PER_SAMPLE_DEFAULT, SEQ_TIMEOUT_DEFAULT.
- Sub-module mod_sample_fifo:
  - Parameter DEPTH, sample_t data.
  - Ports: push/full, pop/empty, head.
  - Pointer-plus-one-extra-bit full/empty detection.
  - Reusable for other audio paths.

Test Plan (CLKS_PER_SAMPLE=16, TIMEOUT=8, FIFO_DEPTH=4):
- Basic run:
  - Stimulus: enable, synth model returns ready 3 cycles after trigger with sound=time*100; i_sample_ready=1.
  - Required: o_trigger pulses every 16 cycles, first 16 cycles after enable. o_time = 0,1,2. Samples 0,100,200 appear in order. Both counters stay 0.
- Timeout:
  - Stimulus: synth answers sample 0 with 0x1234, then never asserts ready.
  - Required: 8 cycles after trigger, o_timeout_count=1 and 0x1234 is pushed again. o_time still advances.
- Backpressure:
  - Stimulus: i_sample_ready=0 for 6 samples.
  - Required: FIFO holds the first 4. o_overrun_count=2. On release, the first 4 samples drain in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, i_sample_ready=1 in the STORE cycle.
  - Required: no overrun, occupancy stays 4.
- Disable mid-sample:
  - Stimulus: drop i_enable in WAIT_READY.
  - Required: that sample completes and is pushed, FSM returns to IDLE, o_busy=0, no further triggers, o_time retained. Re-enable resumes at the next o_time.
- Async reset:
  - Stimulus: assert i_rst mid-WAIT_READY, off the clock edge.
  - Required: outputs go to 0 immediately and no push occurs.
